banked_ram_arb: RTL and testbench
=================================

# banked_ram_arb

Parametrised, banked, byte-writable on-chip RAM with two native-memory-interface requester ports (picorv32 valid/ready style) and a built-in arbiter. It replaces the fixed 64 KB RAM plus external two-master heap mux. Port A carries the CPU and port B a DMA engine. Size, bank count, base address, read latency and arbitration mode are set per instance.

## Interface
Parameters:
- ADDR_BASE, 32'h0001_0000: byte base address of the window; must be aligned to 2**SIZE_LOG2.
- SIZE_LOG2, 16: window size in bytes is 2**SIZE_LOG2; legal range 10..20.
- BANK_LOG2, 2: the RAM has 2**BANK_LOG2 banks; 0..3.
- READ_LATENCY, 1: 1 means raw synchronous RAM output; 2 adds an output register.
- ARB_MODE, 0: 0 is fixed priority (A wins); 1 is round-robin.

Ports (`x` is `a` or `b`):
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- x_valid  in  1  request pending; held until x_ready.
- x_ready  out  1  single-cycle completion pulse.
- x_addr  in  32  byte address; bits [1:0] are ignored.
- x_wdata  in  32  write data.
- x_wstrb  in  4  byte enables; 0 means read.
- x_rdata  out  32  read data; valid only while x_ready is high.
- x_err  out  1  pulses with x_ready when the address is outside the window.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ACCESS, RDWAIT, RESP.
- **IDLE:** if any x_valid is high, latch grant, addr, wdata, wstrb and range check, then go to ACCESS.
- **ACCESS:** drive the selected bank (enable, word index, byte-enables). Then:
  - Write, or out-of-range access: assert x_ready (and x_err if out of range), then go to IDLE.
  - Read with READ_LATENCY=1: go to RESP.
  - Read with READ_LATENCY=2: go to RDWAIT.
- **RDWAIT:** capture the bank output into the output register, then go to RESP.
- **RESP:** assert x_ready and drive x_rdata from the addressed bank, then go to IDLE.
- Address decode:
  - In range when x_addr[31:SIZE_LOG2] == ADDR_BASE[31:SIZE_LOG2].
  - Bank select is addr[SIZE_LOG2-1 -: BANK_LOG2].
  - Word index is addr[SIZE_LOG2-BANK_LOG2-1:2].
- Out-of-range accesses never write memory and return rdata 0.
- Only the addressed bank's byte-enables are asserted. Unselected bytes are unchanged.
- Arbitration, when both valids are high in IDLE:
  - ARB_MODE=0: A is granted.
  - ARB_MODE=1: the port not granted last time is granted. After reset, "last" is B, so A wins the first tie.
- A lone requester is always granted.
- The non-granted port sees x_ready low and must keep its request asserted. It is served in the next IDLE.
- A requester deasserts valid in the cycle after ready. The FSM spends at least one cycle in IDLE between grants, so a request is never re-granted.
- Memory contents are not reset and are not initialised.

## Timing
Cycle 0 is the cycle in which valid is first seen in IDLE with a grant.
- Write latency: ready in cycle 1.
- Read latency:
  - READ_LATENCY=1: ready and rdata in cycle 2.
  - READ_LATENCY=2: ready and rdata in cycle 3.
- Back-to-back throughput from one port: a write every 2 cycles; a read every 3 (or 4) cycles.
- Reset values: x_ready=0, x_err=0, x_rdata=0, busy=0, state=IDLE, last-grant=B.
- Reset asserted mid-access:
  - The FSM goes to IDLE immediately and no ready is issued.
  - A write whose ACCESS edge has not completed is dropped.
- x_rdata is 0 whenever x_ready is low.
- wstrb change while valid is held: not a legal stimulus. The latched copy from cycle 0 is used.

## Structure
- Package `banked_ram_pkg`:
  - FSM state enum.
  - ARB_FIXED / ARB_RR constants.
  - A function computing the bank and word-index widths from SIZE_LOG2 and BANK_LOG2.
- Sub-module `ram_bank`:
  - Parameterised depth (2**(SIZE_LOG2-BANK_LOG2-2) words × 32 bits).
  - 4 byte write-enables, enable input, synchronous read.
  - One instance per bank via a generate loop.
- The top level holds the arbiter, FSM, request latches, decode and read mux.

## Test plan
1. **Write then read, port A.** A writes 0xDEADBEEF to 0x0001_0010 with wstrb 4'hF, then reads it back. a_ready is seen in cycle 1 for the write and in cycle 2 for the read (READ_LATENCY=1), with rdata 0xDEADBEEF.
2. **Byte strobes.** Fill 0x0001_8000 with 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101. Read returns 0x11BB33DD.
3. **Simultaneous requests.** A and B request in the same cycle.
   - ARB_MODE=0: A completes first, B follows.
   - ARB_MODE=1, repeated ties: grant alternates A, B, A, B.
4. **Out-of-range access.** Access 0x0003_0000 with a write. x_ready and x_err pulse in cycle 1. A follow-up read shows no memory changed; a read of that out-of-range address returns rdata 0.
5. **Bank boundary.** With BANK_LOG2=2, write distinct values to the last word of bank 0 (0x0001_3FFC) and the first word of bank 1 (0x0001_4000). Both read back intact.
6. **Reset mid-read.** With READ_LATENCY=2, drop resetn during RDWAIT. busy and ready go to 0 immediately. After release, a new read completes normally in cycle 3.

Source files
------------

// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for the banked RAM with built-in two-port arbiter.
// Holds the FSM state encoding, arbitration mode constants and decode widths.
package banked_ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT,
      RESP
   } state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Bank-select width never drops below one bit so a single-bank build still
   // has a legal select signal; the word index covers what is left of the window.
   function automatic int idx_width(input int size_log2, input int bank_log2,
                                    input bit bank_field);
      if (bank_field)
         return (bank_log2 > 0) ? bank_log2 : 1;
      return size_log2 - bank_log2 - 2;
   endfunction

endpackage

// File: rtl/ram_bank.sv
// One 32-bit-wide RAM bank with per-byte write enables and a synchronous read.
// The read port only updates when the bank is enabled, so its output holds.
module ram_bank
   import banked_ram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [3:0]            we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i])
               mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/banked_ram_arb.sv
// Banked byte-writable RAM shared by a CPU port (A) and a DMA port (B).
// Arbiter, request latches, address decode, FSM and read mux live here.
module banked_ram_arb
   import banked_ram_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE    = 32'h0001_0000,
   parameter int          SIZE_LOG2    = 16,
   parameter int          BANK_LOG2    = 2,
   parameter int          READ_LATENCY = 1,
   parameter int          ARB_MODE     = ARB_FIXED
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_wstrb,
   output logic [31:0] a_rdata,
   output logic        a_err,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_wstrb,
   output logic [31:0] b_rdata,
   output logic        b_err,
   output logic        busy
);

   localparam int BANK_W    = idx_width(SIZE_LOG2, BANK_LOG2, 1'b1);
   localparam int WORD_W    = idx_width(SIZE_LOG2, BANK_LOG2, 1'b0);
   localparam int NUM_BANKS = 2**BANK_LOG2;

   state_t              state;
   state_t              state_nxt;
   logic                resp;
   logic                sel_b;
   logic                grant_b;
   logic                last_b;
   logic [31:0]         req_addr;
   logic [31:0]         req_wdata;
   logic [3:0]          req_wstrb;
   logic [SIZE_LOG2-1:2] addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          wstrb_q;
   logic                in_range_q;
   logic [31:0]         rdata_q;
   logic [31:0]         resp_data;
   logic [BANK_W-1:0]   bank_sel;
   logic [WORD_W-1:0]   word_idx;
   logic [31:0]         bank_rdata [NUM_BANKS];
   logic                unused_addr;

   assign unused_addr = ^{a_addr[1:0], b_addr[1:0]};

   // Round-robin gives a tie to whichever port was not granted last time.
   assign sel_b     = b_valid && (!a_valid || (ARB_MODE == ARB_RR && !last_b));
   assign req_addr  = sel_b ? b_addr  : a_addr;
   assign req_wdata = sel_b ? b_wdata : a_wdata;
   assign req_wstrb = sel_b ? b_wstrb : a_wstrb;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         grant_b    <= 1'b0;
         last_b     <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         in_range_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (a_valid || b_valid)) begin
            grant_b    <= sel_b;
            last_b     <= sel_b;
            addr_q     <= req_addr[SIZE_LOG2-1:2];
            wdata_q    <= req_wdata;
            wstrb_q    <= req_wstrb;
            in_range_q <= (req_addr[31:SIZE_LOG2] == ADDR_BASE[31:SIZE_LOG2]);
         end
         if (state == RDWAIT)
            rdata_q <= bank_rdata[bank_sel];
      end
   end

   always_comb begin
      state_nxt = state;
      resp      = 1'b0;
      case (state)
         IDLE: begin
            if (a_valid || b_valid)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            if (wstrb_q != 4'h0 || !in_range_q) begin
               resp      = 1'b1;
               state_nxt = IDLE;
            end else if (READ_LATENCY == 2) begin
               state_nxt = RDWAIT;
            end else begin
               state_nxt = RESP;
            end
         end
         RDWAIT: state_nxt = RESP;
         RESP: begin
            resp      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   if (BANK_LOG2 > 0) begin : g_bank_sel
      assign bank_sel = addr_q[SIZE_LOG2-1 -: BANK_LOG2];
   end else begin : g_single_bank
      assign bank_sel = '0;
   end
   assign word_idx = addr_q[SIZE_LOG2-BANK_LOG2-1:2];

   // Only the addressed bank is enabled, and never for an out-of-window access.
   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      logic bank_en;
      assign bank_en = (state == ACCESS) && in_range_q && (bank_sel == BANK_W'(i));
      ram_bank #(
         .DEPTH_LOG2 (WORD_W)
      ) u_bank (
         .clk   (clk),
         .en    (bank_en),
         .we    (bank_en ? wstrb_q : 4'h0),
         .addr  (word_idx),
         .wdata (wdata_q),
         .rdata (bank_rdata[i])
      );
   end

   assign resp_data = (state != RESP) ? 32'h0 :
                      (READ_LATENCY == 2) ? rdata_q : bank_rdata[bank_sel];

   assign a_ready = resp && !grant_b;
   assign b_ready = resp && grant_b;
   assign a_err   = a_ready && !in_range_q;
   assign b_err   = b_ready && !in_range_q;
   assign a_rdata = a_ready ? resp_data : 32'h0;
   assign b_rdata = b_ready ? resp_data : 32'h0;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_banked_ram_arb.sv
// Bench for banked_ram_arb: dut 0 is fixed-priority/latency-1, dut 1 is round-robin/latency-2.
// A sparse word map and per-DUT last-grant tracker predict every response.
module tb_banked_ram_arb;

   logic        clk;
   logic        resetn  [2];
   logic        a_valid [2];
   logic        b_valid [2];
   logic [31:0] a_addr  [2];
   logic [31:0] b_addr  [2];
   logic [31:0] a_wdata [2];
   logic [31:0] b_wdata [2];
   logic [3:0]  a_wstrb [2];
   logic [3:0]  b_wstrb [2];
   logic        a_ready [2];
   logic        b_ready [2];
   logic        a_err   [2];
   logic        b_err   [2];
   logic [31:0] a_rdata [2];
   logic [31:0] b_rdata [2];
   logic        busy    [2];

   int checks;
   int errors;

   logic [31:0] model [logic [30:0]];
   int          last_b_m [2];
   int          arb_m    [2] = '{0, 1};
   int          rd_lat   [2] = '{2, 3};

   banked_ram_arb #(
      .ADDR_BASE (32'h0001_0000), .SIZE_LOG2 (16), .BANK_LOG2 (2),
      .READ_LATENCY (1), .ARB_MODE (0)
   ) dut0 (
      .clk (clk), .resetn (resetn[0]),
      .a_valid (a_valid[0]), .a_ready (a_ready[0]), .a_addr (a_addr[0]),
      .a_wdata (a_wdata[0]), .a_wstrb (a_wstrb[0]), .a_rdata (a_rdata[0]), .a_err (a_err[0]),
      .b_valid (b_valid[0]), .b_ready (b_ready[0]), .b_addr (b_addr[0]),
      .b_wdata (b_wdata[0]), .b_wstrb (b_wstrb[0]), .b_rdata (b_rdata[0]), .b_err (b_err[0]),
      .busy (busy[0])
   );

   banked_ram_arb #(
      .ADDR_BASE (32'h0001_0000), .SIZE_LOG2 (16), .BANK_LOG2 (2),
      .READ_LATENCY (2), .ARB_MODE (1)
   ) dut1 (
      .clk (clk), .resetn (resetn[1]),
      .a_valid (a_valid[1]), .a_ready (a_ready[1]), .a_addr (a_addr[1]),
      .a_wdata (a_wdata[1]), .a_wstrb (a_wstrb[1]), .a_rdata (a_rdata[1]), .a_err (a_err[1]),
      .b_valid (b_valid[1]), .b_ready (b_ready[1]), .b_addr (b_addr[1]),
      .b_wdata (b_wdata[1]), .b_wstrb (b_wstrb[1]), .b_rdata (b_rdata[1]), .b_err (b_err[1]),
      .busy (busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic port_ready(input int d, input int p);
      return (p != 0) ? b_ready[d] : a_ready[d];
   endfunction

   function automatic logic port_err(input int d, input int p);
      return (p != 0) ? b_err[d] : a_err[d];
   endfunction

   function automatic logic [31:0] port_rdata(input int d, input int p);
      return (p != 0) ? b_rdata[d] : a_rdata[d];
   endfunction

   function automatic logic in_window(input logic [31:0] addr);
      return addr[31:16] == 16'h0001;
   endfunction

   function automatic logic [30:0] mkey(input int d, input logic [31:0] addr);
      return {d[0], addr[31:2]};
   endfunction

   task automatic model_write(input int d, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
      logic [31:0] word;
      logic [30:0] k;
      k    = mkey(d, addr);
      word = model.exists(k) ? model[k] : 32'h0;
      for (int i = 0; i < 4; i++)
         if (wstrb[i]) word[i*8 +: 8] = wdata[i*8 +: 8];
      model[k] = word;
   endtask

   task automatic set_req(input int d, input int p, input logic v, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      if (p != 0) begin
         b_valid[d] = v; b_addr[d] = addr; b_wdata[d] = wdata; b_wstrb[d] = wstrb;
      end else begin
         a_valid[d] = v; a_addr[d] = addr; a_wdata[d] = wdata; a_wstrb[d] = wstrb;
      end
   endtask

   // One request from one port, timed in cycles from the grant edge.
   task automatic applyStimulus(input int d, input int p, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      int          lat;
      int          exp_lat;
      logic        got;
      logic        inr;
      logic [31:0] exp_data;
      logic [30:0] k;
      inr      = in_window(addr);
      k        = mkey(d, addr);
      exp_lat  = (wstrb != 4'h0 || !inr) ? 1 : rd_lat[d];
      exp_data = (wstrb == 4'h0 && inr && model.exists(k)) ? model[k] : 32'h0;
      set_req(d, p, 1'b1, addr, wdata, wstrb);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         got = port_ready(d, p);
         checkOutput("other_ready_low", {31'h0, port_ready(d, 1 - p)}, 32'h0);
         if (!got)
            checkOutput("rdata_zero_wait", port_rdata(d, p), 32'h0);
      end
      checkOutput("latency", lat, exp_lat);
      checkOutput("err", {31'h0, port_err(d, p)}, {31'h0, !inr});
      checkOutput("rdata", port_rdata(d, p), exp_data);
      set_req(d, p, 1'b0, 32'h0, 32'h0, 4'h0);
      if (inr && wstrb != 4'h0)
         model_write(d, addr, wdata, wstrb);
      last_b_m[d] = p;
      @(negedge clk);
   endtask

   // Both ports raise a write together; the predicted winner must finish first.
   task automatic tie_writes(input int d, input logic [31:0] addr_a, input logic [31:0] wd_a,
                             input logic [31:0] addr_b, input logic [31:0] wd_b);
      int first_b;
      int t_a;
      int t_b;
      int cyc;
      first_b = (arb_m[d] == 1) ? ((last_b_m[d] != 0) ? 0 : 1) : 0;
      set_req(d, 0, 1'b1, addr_a, wd_a, 4'hF);
      set_req(d, 1, 1'b1, addr_b, wd_b, 4'hF);
      t_a = -1;
      t_b = -1;
      cyc = 0;
      while ((t_a < 0 || t_b < 0) && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (a_ready[d] && t_a < 0) begin
            t_a = cyc;
            set_req(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
         end
         if (b_ready[d] && t_b < 0) begin
            t_b = cyc;
            set_req(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
      checkOutput("tie_first_lat",  (first_b != 0) ? t_b : t_a, 1);
      checkOutput("tie_second_lat", (first_b != 0) ? t_a : t_b, 3);
      model_write(d, addr_a, wd_a, 4'hF);
      model_write(d, addr_b, wd_b, 4'hF);
      last_b_m[d] = (first_b != 0) ? 0 : 1;
      set_req(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
   endtask

   task automatic random_ops(input int d, input int n);
      logic [31:0] addr;
      logic [3:0]  wstrb;
      int          kind;
      int          p;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 9);
         p    = $urandom_range(0, 1);
         addr = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 3)) << 2);
         if (kind == 0) begin
            addr  = 32'h0002_0000 | (addr & 32'h0000_FFFC);
            wstrb = 4'($urandom_range(0, 15));
         end else if (kind <= 4) begin
            wstrb = model.exists(mkey(d, addr)) ? 4'h0 : 4'hF;
         end else begin
            wstrb = model.exists(mkey(d, addr)) ? 4'($urandom_range(1, 15)) : 4'hF;
         end
         applyStimulus(d, p, addr, $urandom, wstrb);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_b_m[0] = 1;
      last_b_m[1] = 1;
      for (int d = 0; d < 2; d++) begin
         resetn[d] = 1'b0;
         set_req(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
         set_req(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      repeat (3) @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         checkOutput("reset_busy",    {31'h0, busy[d]},    32'h0);
         checkOutput("reset_a_ready", {31'h0, a_ready[d]}, 32'h0);
         checkOutput("reset_b_ready", {31'h0, b_ready[d]}, 32'h0);
         checkOutput("reset_a_err",   {31'h0, a_err[d]},   32'h0);
         checkOutput("reset_a_rdata", a_rdata[d],          32'h0);
         checkOutput("reset_b_rdata", b_rdata[d],          32'h0);
      end
      resetn[0] = 1'b1;
      resetn[1] = 1'b1;
      @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 0, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
         applyStimulus(d, 0, 32'h0001_0010, 32'h0, 4'h0);

         applyStimulus(d, 0, 32'h0001_8000, 32'h1122_3344, 4'hF);
         applyStimulus(d, 0, 32'h0001_8000, 32'hAABB_CCDD, 4'b0101);
         applyStimulus(d, 1, 32'h0001_8000, 32'h0, 4'h0);

         applyStimulus(d, 0, 32'h0001_0000, 32'hCAFE_F00D, 4'hF);
         applyStimulus(d, 1, 32'h0003_0000, 32'h1234_5678, 4'hF);
         applyStimulus(d, 0, 32'h0001_0000, 32'h0, 4'h0);
         applyStimulus(d, 1, 32'h0003_0000, 32'h0, 4'h0);

         applyStimulus(d, 1, 32'h0001_3FFC, 32'h0BAD_0000, 4'hF);
         applyStimulus(d, 1, 32'h0001_4000, 32'h0000_1BAD, 4'hF);
         applyStimulus(d, 0, 32'h0001_3FFC, 32'h0, 4'h0);
         applyStimulus(d, 0, 32'h0001_4000, 32'h0, 4'h0);
      end

      tie_writes(0, 32'h0001_0100, 32'hA000_0001, 32'h0001_0104, 32'hB000_0001);
      tie_writes(0, 32'h0001_0100, 32'hA000_0002, 32'h0001_0104, 32'hB000_0002);
      applyStimulus(0, 1, 32'h0001_0100, 32'h0, 4'h0);
      applyStimulus(0, 0, 32'h0001_0104, 32'h0, 4'h0);

      applyStimulus(1, 0, 32'h0001_0200, 32'h5555_0000, 4'hF);
      tie_writes(1, 32'h0001_0100, 32'hA000_0011, 32'h0001_0104, 32'hB000_0011);
      tie_writes(1, 32'h0001_0100, 32'hA000_0012, 32'h0001_0104, 32'hB000_0012);
      applyStimulus(1, 1, 32'h0001_0104, 32'h0, 4'h0);
      tie_writes(1, 32'h0001_0100, 32'hA000_0013, 32'h0001_0104, 32'hB000_0013);
      applyStimulus(1, 1, 32'h0001_0100, 32'h0, 4'h0);
      applyStimulus(1, 0, 32'h0001_0104, 32'h0, 4'h0);

      random_ops(0, 60);
      random_ops(1, 60);

      // Reset lands during RDWAIT of a latency-2 read.
      set_req(1, 0, 1'b1, 32'h0001_3FFC, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rdwait_busy", {31'h0, busy[1]}, 32'h1);
      #1 resetn[1] = 1'b0;
      #1;
      checkOutput("midrst_busy",  {31'h0, busy[1]},    32'h0);
      checkOutput("midrst_ready", {31'h0, a_ready[1]}, 32'h0);
      checkOutput("midrst_rdata", a_rdata[1],          32'h0);
      set_req(1, 0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("midrst_no_ready", {31'h0, a_ready[1]}, 32'h0);
      @(negedge clk);
      resetn[1] = 1'b1;
      last_b_m[1] = 1;
      @(negedge clk);
      applyStimulus(1, 0, 32'h0001_3FFC, 32'h0, 4'h0);
      tie_writes(1, 32'h0001_0300, 32'hC000_0001, 32'h0001_0304, 32'hD000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
